mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/arb_rr2.sv | 21 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester data-memory arbiter:
// FSM state encoding, requester ids and the default memory depth.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;

  localparam int DEF_MEM_DEPTH = 256;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between CPU and DMA.
// Ports: req_cpu/req_dma requests, last = last served id, win = winner id.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic req_cpu,
  input  logic req_dma,
  input  logic last,
  output logic win
);

  // On a tie the requester not served last goes next.
  always_comb begin
    win = ID_CPU;
    if (req_cpu && req_dma)
      win = ~last;
    else if (req_dma)
      win = ID_DMA;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA word accesses onto one single-port memory.
// Ports: clk/reset, cpu_* and dma_* requesters, mem_* memory side, busy, grant_id.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        err_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        owner;
  logic        last;
  logic        win;
  logic        oor;
  logic        any_req;
  logic        acc;
  logic        rsp;

  arb_rr2 u_rr (
    .req_cpu (cpu_req),
    .req_dma (dma_req),
    .last    (last),
    .win     (win)
  );

  assign any_req = cpu_req | dma_req;
  assign oor     = addr_q >= 32'(MEM_DEPTH);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (any_req) state_n = ACCESS;
      ACCESS:
        if (oor || LAT_M1 == 4'd0) state_n = RESP;
        else state_n = WAIT;
      WAIT:
        if (cnt == 4'd1) state_n = RESP;
      RESP:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      owner   <= ID_CPU;
      last    <= ID_DMA;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE:
          if (any_req) begin
            owner   <= win;
            last    <= win;
            err_q   <= 1'b0;
            we_q    <= win ? dma_we : cpu_we;
            addr_q  <= win ? dma_addr : cpu_addr;
            wdata_q <= win ? dma_wdata : cpu_wdata;
          end
        ACCESS: begin
          cnt   <= LAT_M1;
          err_q <= oor;
          if (state_n == RESP)
            rdata_q <= (!we_q && !oor) ? mem_rdata : '0;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (state_n == RESP)
            rdata_q <= we_q ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign acc = (state == ACCESS);
  assign rsp = (state == RESP);

  assign mem_read  = acc & ~oor & ~we_q;
  assign mem_write = acc & ~oor & we_q;
  assign mem_addr  = acc ? addr_q : '0;
  assign mem_wdata = acc ? wdata_q : '0;

  assign cpu_ack   = rsp & (owner == ID_CPU);
  assign dma_ack   = rsp & (owner == ID_DMA);
  assign cpu_err   = cpu_ack & err_q;
  assign dma_err   = dma_ack & err_q;
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign dma_rdata = dma_ack ? rdata_q : '0;

  assign busy     = (state != IDLE);
  assign grant_id = busy & owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: latency 1 and latency 3 arbiters side by side,
// each with its own simple word memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // instance A: MEM_LATENCY = 1
  logic        a_cpu_req, a_cpu_we, a_dma_req, a_dma_we;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_dma_addr, a_dma_wdata;
  logic        a_cpu_ack, a_cpu_err, a_dma_ack, a_dma_err;
  logic [31:0] a_cpu_rdata, a_dma_rdata;
  logic        a_mem_read, a_mem_write, a_busy, a_grant_id;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // instance B: MEM_LATENCY = 3
  logic        b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_dma_addr, b_dma_wdata;
  logic        b_cpu_ack, b_cpu_err, b_dma_ack, b_dma_err;
  logic [31:0] b_cpu_rdata, b_dma_rdata;
  logic        b_mem_read, b_mem_write, b_busy, b_grant_id;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.MEM_LATENCY(1), .MEM_DEPTH(256)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we),
    .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_err(a_cpu_err), .cpu_rdata(a_cpu_rdata),
    .dma_req(a_dma_req), .dma_we(a_dma_we),
    .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_ack(a_dma_ack), .dma_err(a_dma_err), .dma_rdata(a_dma_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata),
    .busy(a_busy), .grant_id(a_grant_id)
  );

  mem_arbiter #(.MEM_LATENCY(3), .MEM_DEPTH(256)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_err(b_cpu_err), .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_we(b_dma_we),
    .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_ack(b_dma_ack), .dma_err(b_dma_err), .dma_rdata(b_dma_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  // memories: data follows the strobe address, then holds it
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [7:0]  ra_a = 8'd0;
  logic [7:0]  ra_b = 8'd0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] <= 32'h1000_0000 | 32'(i);
      mem_b[i] <= 32'h2000_0000 | 32'(i);
    end
    mem_a[5]  <= 32'hDEAD_BEEF;
    mem_a[6]  <= 32'h0000_0066;
    mem_a[44] <= 32'h4444_4444;
    mem_b[7]  <= 32'hCAFE_F00D;
    mem_b[9]  <= 32'h0000_0099;
  end

  always @(posedge clk) begin
    if (a_mem_write) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
    if (a_mem_read) ra_a <= a_mem_addr[7:0];
    if (b_mem_write) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    if (b_mem_read) ra_b <= b_mem_addr[7:0];
  end

  assign a_mem_rdata = a_mem_read ? mem_a[a_mem_addr[7:0]] : mem_a[ra_a];
  assign b_mem_rdata = b_mem_read ? mem_b[b_mem_addr[7:0]] : mem_b[ra_b];

  `define CHK(tag, obs, exp) \
    begin \
      n_chk++; \
      assert ((obs) === (exp)) else begin \
        n_fail++; \
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp); \
      end \
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_id;

  initial begin
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
    a_dma_req = 0; a_dma_we = 0; a_dma_addr = 0; a_dma_wdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;
    reset = 1;
    tick();
    tick();
    `CHK("rst_busy", a_busy, 1'b0)
    `CHK("rst_rd", a_mem_read, 1'b0)
    `CHK("rst_ack", a_cpu_ack, 1'b0)
    reset = 0;
    `CHK("post_rst_busy", b_busy, 1'b0)
    `CHK("post_rst_gid", b_grant_id, 1'b0)

    // CPU read of address 5, latency 1
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'd5;
    `CHK("rd_c0_strobe", a_mem_read, 1'b0)
    tick();
    `CHK("rd_c1_strobe", a_mem_read, 1'b1)
    `CHK("rd_c1_addr", a_mem_addr, 32'd5)
    `CHK("rd_c1_wr", a_mem_write, 1'b0)
    `CHK("rd_c1_ack", a_cpu_ack, 1'b0)
    tick();
    `CHK("rd_c2_ack", a_cpu_ack, 1'b1)
    `CHK("rd_c2_data", a_cpu_rdata, 32'hDEAD_BEEF)
    `CHK("rd_c2_err", a_cpu_err, 1'b0)
    `CHK("rd_c2_strobe", a_mem_read, 1'b0)
    `CHK("rd_c2_addr", a_mem_addr, 32'd0)
    `CHK("rd_c2_dack", a_dma_ack, 1'b0)
    a_cpu_req = 0;
    tick();
    `CHK("rd_c3_ack", a_cpu_ack, 1'b0)
    `CHK("rd_c3_busy", a_busy, 1'b0)

    // tie from reset release: CPU, DMA, CPU, DMA
    reset = 1;
    a_cpu_req = 1; a_cpu_addr = 32'd5;
    a_dma_req = 1; a_dma_we = 0; a_dma_addr = 32'd6;
    tick();
    tick();
    reset = 0;
    `CHK("rr_start_busy", a_busy, 1'b0)
    for (int g = 0; g < 4; g++) begin
      exp_id = (g % 2 == 1);
      tick();
      `CHK("rr_gid", a_grant_id, exp_id)
      `CHK("rr_busy", a_busy, 1'b1)
      tick();
      `CHK("rr_cpu_ack", a_cpu_ack, ~exp_id)
      `CHK("rr_dma_ack", a_dma_ack, exp_id)
      if (exp_id)
        `CHK("rr_dma_data", a_dma_rdata, 32'h0000_0066)
      else
        `CHK("rr_cpu_data", a_cpu_rdata, 32'hDEAD_BEEF)
      if (g == 3) begin
        a_cpu_req = 0;
        a_dma_req = 0;
      end
      tick();
    end
    `CHK("rr_end_busy", a_busy, 1'b0)

    // DMA write, out of range
    a_dma_req = 1; a_dma_we = 1;
    a_dma_addr = 32'd300; a_dma_wdata = 32'h0000_1234;
    tick();
    `CHK("oor_c1_wr", a_mem_write, 1'b0)
    `CHK("oor_c1_rd", a_mem_read, 1'b0)
    `CHK("oor_c1_gid", a_grant_id, 1'b1)
    tick();
    `CHK("oor_c2_ack", a_dma_ack, 1'b1)
    `CHK("oor_c2_err", a_dma_err, 1'b1)
    `CHK("oor_c2_cack", a_cpu_ack, 1'b0)
    `CHK("oor_c2_data", a_dma_rdata, 32'd0)
    a_dma_req = 0;
    tick();
    `CHK("oor_mem", mem_a[44], 32'h4444_4444)

    // DMA legal write, then CPU reads it back
    a_dma_req = 1; a_dma_we = 1;
    a_dma_addr = 32'd10; a_dma_wdata = 32'h0000_A5A5;
    tick();
    `CHK("wr_c1_wr", a_mem_write, 1'b1)
    `CHK("wr_c1_rd", a_mem_read, 1'b0)
    `CHK("wr_c1_wdata", a_mem_wdata, 32'h0000_A5A5)
    tick();
    `CHK("wr_c2_ack", a_dma_ack, 1'b1)
    `CHK("wr_c2_err", a_dma_err, 1'b0)
    `CHK("wr_c2_data", a_dma_rdata, 32'd0)
    a_dma_req = 0;
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 32'd10;
    tick();
    tick();
    tick();
    `CHK("wr_rb_ack", a_cpu_ack, 1'b1)
    `CHK("wr_rb_data", a_cpu_rdata, 32'h0000_A5A5)
    a_cpu_req = 0;
    tick();

    // latency 3 read, address changed mid-access
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'd7;
    tick();
    `CHK("l3_c1_busy", b_busy, 1'b1)
    `CHK("l3_c1_rd", b_mem_read, 1'b1)
    `CHK("l3_c1_addr", b_mem_addr, 32'd7)
    b_cpu_addr = 32'd9;
    tick();
    `CHK("l3_c2_busy", b_busy, 1'b1)
    `CHK("l3_c2_rd", b_mem_read, 1'b0)
    `CHK("l3_c2_ack", b_cpu_ack, 1'b0)
    tick();
    `CHK("l3_c3_busy", b_busy, 1'b1)
    `CHK("l3_c3_ack", b_cpu_ack, 1'b0)
    tick();
    `CHK("l3_c4_busy", b_busy, 1'b1)
    `CHK("l3_c4_ack", b_cpu_ack, 1'b1)
    `CHK("l3_c4_data", b_cpu_rdata, 32'hCAFE_F00D)
    b_cpu_req = 0;
    tick();
    `CHK("l3_c5_busy", b_busy, 1'b0)
    `CHK("l3_c5_ack", b_cpu_ack, 1'b0)

    // reset during WAIT of a DMA read
    b_dma_req = 1; b_dma_we = 0; b_dma_addr = 32'd7;
    tick();
    tick();
    `CHK("rw_wait_busy", b_busy, 1'b1)
    `CHK("rw_wait_gid", b_grant_id, 1'b1)
    reset = 1;
    b_dma_req = 0;
    tick();
    `CHK("rw_busy", b_busy, 1'b0)
    `CHK("rw_gid", b_grant_id, 1'b0)
    `CHK("rw_dack", b_dma_ack, 1'b0)
    `CHK("rw_rd", b_mem_read, 1'b0)
    `CHK("rw_addr", b_mem_addr, 32'd0)
    reset = 0;
    tick();
    `CHK("rw_after_dack", b_dma_ack, 1'b0)
    `CHK("rw_after_busy", b_busy, 1'b0)
    b_cpu_req = 1; b_cpu_addr = 32'd7;
    tick();
    `CHK("rw_cpu_gid", b_grant_id, 1'b0)
    tick();
    tick();
    `CHK("rw_cpu_noack", b_cpu_ack, 1'b0)
    tick();
    `CHK("rw_cpu_ack", b_cpu_ack, 1'b1)
    `CHK("rw_cpu_data", b_cpu_rdata, 32'hCAFE_F00D)
    `CHK("rw_cpu_dack", b_dma_ack, 1'b0)
    b_cpu_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  // never both strobes at once
  always @(negedge clk) begin
    if (a_mem_read && a_mem_write) begin
      n_fail++;
      $error("FAIL both_strobes_a: got 1 expected 0");
    end
    if (b_mem_read && b_mem_write) begin
      n_fail++;
      $error("FAIL both_strobes_b: got 1 expected 0");
    end
  end

endmodule
